// File: rtl/load_pkg.sv
// Shared encodings for the load alignment unit: access sizes and FSM states.
`default_nettype none

package load_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/load_extract.sv
// Selects the addressed bytes from a two-word window and sign/zero-extends them.
`default_nettype none

module load_extract
    import load_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0]         pair_i,
    input  logic [$clog2(XLEN/8)-1:0] offset_i,
    input  logic [1:0]                size_i,
    input  logic                      unsigned_i,
    output logic [XLEN-1:0]           data_o
);

    logic [XLEN-1:0] w_low;
    logic [XLEN-1:0] w_mask;
    logic            w_sign;

    assign w_low = XLEN'(pair_i >> {offset_i, 3'b000});

    // A full-width access leaves ~mask at zero, so unsigned_i has no effect there.
    always_comb begin
        w_mask = '1;
        w_sign = w_low[XLEN-1];
        case (size_i)
            SZ_B: begin
                w_mask = XLEN'(8'hFF);
                w_sign = w_low[7];
            end
            SZ_H: begin
                w_mask = XLEN'(16'hFFFF);
                w_sign = w_low[15];
            end
            SZ_W: begin
                w_mask = XLEN'(32'hFFFF_FFFF);
                w_sign = w_low[31];
            end
            default: begin
                w_mask = '1;
                w_sign = w_low[XLEN-1];
            end
        endcase
    end

    assign data_o = (w_low & w_mask) | ((w_sign && !unsigned_i) ? ~w_mask : '0);

endmodule

`default_nettype wire

// File: rtl/load_align_unit.sv
// Single-outstanding load unit: aligned word fetches, optional two-beat split
// for word-crossing loads, and extended writeback with a ready/valid handshake.
`default_nettype none

module load_align_unit
    import load_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [4:0]      req_rd,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_err,
    input  logic            wb_ready
);

    localparam int NBYTES = XLEN / 8;
    localparam int OFF_W  = $clog2(NBYTES);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("load_align_unit: XLEN must be 32 or 64");
    end

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [4:0]        rd_q, rd_d;
    logic              cross_q, cross_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              wb_err_q, wb_err_d;

    logic [OFF_W-1:0]  w_req_off;
    logic [4:0]        w_req_end;
    logic              w_req_cross;
    logic              w_req_illegal;
    logic [XLEN-1:0]   w_ext_lo;
    logic [XLEN-1:0]   w_ext_hi;
    logic [XLEN-1:0]   w_ext_data;

    assign w_req_off     = req_addr[OFF_W-1:0];
    assign w_req_end     = 5'(w_req_off) + (5'd1 << req_size);
    assign w_req_cross   = w_req_end > 5'(NBYTES);
    assign w_req_illegal = (req_size == SZ_D && XLEN == 32) || (w_req_cross && !ALLOW_MISALIGNED);

    // Bypass the arriving beat so the result is ready in the same cycle it lands.
    assign w_ext_lo = (state_q == ST_WAIT0) ? mem_resp_data : lo_q;
    assign w_ext_hi = (state_q == ST_WAIT1) ? mem_resp_data : hi_q;

    load_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .pair_i     ({w_ext_hi, w_ext_lo}),
        .offset_i   (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (w_ext_data)
    );

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rd_d       = rd_q;
        cross_d    = cross_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        mem_addr_d = mem_addr_q;
        wb_data_d  = wb_data_q;
        wb_err_d   = wb_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    off_d   = w_req_off;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    rd_d    = req_rd;
                    cross_d = w_req_cross;
                    if (w_req_illegal) begin
                        wb_data_d = '0;
                        wb_err_d  = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        wb_err_d   = 1'b0;
                        mem_addr_d = {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                        state_d    = ST_REQ0;
                    end
                end
            end
            ST_REQ0: begin
                if (mem_req_ready) state_d = ST_WAIT0;
            end
            ST_WAIT0: begin
                if (mem_resp_valid) begin
                    lo_d = mem_resp_data;
                    if (cross_q) begin
                        mem_addr_d = mem_addr_q + XLEN'(NBYTES);
                        state_d    = ST_REQ1;
                    end else begin
                        wb_data_d = w_ext_data;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_REQ1: begin
                if (mem_req_ready) state_d = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (mem_resp_valid) begin
                    hi_d      = mem_resp_data;
                    wb_data_d = w_ext_data;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (wb_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            rd_q       <= '0;
            cross_q    <= 1'b0;
            lo_q       <= '0;
            hi_q       <= '0;
            mem_addr_q <= '0;
            wb_data_q  <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            rd_q       <= rd_d;
            cross_q    <= cross_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            mem_addr_q <= mem_addr_d;
            wb_data_q  <= wb_data_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign mem_req_valid = (state_q == ST_REQ0) || (state_q == ST_REQ1);
    assign mem_addr      = mem_addr_q;
    assign wb_valid      = (state_q == ST_RESP);
    assign wb_data       = wb_data_q;
    assign wb_rd         = rd_q;
    assign wb_err        = wb_err_q;

endmodule

`default_nettype wire

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit (XLEN=32) with a queue-based result scoreboard.
`default_nettype none

module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // Instance A: misaligned loads split into two beats
    logic        req_valid, req_ready, req_unsigned;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [4:0]  req_rd;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [31:0] mem_addr, mem_resp_data;
    logic        wb_valid, wb_err, wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    // Instance B: misaligned loads reported as errors
    logic        req_valid_b, req_ready_b;
    logic        mem_req_valid_b, wb_valid_b, wb_err_b, wb_ready_b;
    logic [31:0] mem_addr_b, wb_data_b;
    logic [4:0]  wb_rd_b;

    load_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_err(wb_err),
        .wb_ready(wb_ready)
    );

    load_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(32'h0000_0102),
        .req_size(2'd2), .req_unsigned(1'b0), .req_rd(5'd9),
        .mem_req_valid(mem_req_valid_b), .mem_req_ready(1'b1), .mem_addr(mem_addr_b),
        .mem_resp_valid(1'b0), .mem_resp_data(32'h0),
        .wb_valid(wb_valid_b), .wb_data(wb_data_b), .wb_rd(wb_rd_b), .wb_err(wb_err_b),
        .wb_ready(wb_ready_b)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0100: mem_rd = 32'h8899_AABB;
            32'h0000_0104: mem_rd = 32'h1122_3344;
            default:       mem_rd = 32'hDEAD_BEEF;
        endcase
    endfunction

    // Issues one load on instance A, acts as a one-cycle memory, then drains writeback.
    task automatic run_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [4:0] rd, input logic [31:0] exp_data,
                            input logic exp_err, input int exp_beats, input int exp_lat,
                            input int stall);
        exp_t        e;
        exp_t        got_e;
        logic [31:0] baddr[$];
        logic [31:0] paddr;
        logic        pend;
        int          lat;
        bit          seen;
        e.data = exp_data; e.err = exp_err; e.rd = rd;
        sb.push_back(e);
        pend = 1'b0; paddr = '0; lat = 0; seen = 1'b0;
        check({name, ":req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_addr = addr; req_size = size; req_unsigned = uns; req_rd = rd;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            req_valid      = 1'b0;
            mem_resp_valid = 1'b0;
            if (pend) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_rd(paddr);
                pend           = 1'b0;
            end
            if (mem_req_valid) begin
                baddr.push_back(mem_addr);
                paddr = mem_addr;
                pend  = 1'b1;
            end
            if (wb_valid) begin
                lat  = cyc;
                seen = 1'b1;
                break;
            end
        end
        check({name, ":wb_seen"}, 64'(seen), 64'd1);
        check({name, ":latency"}, 64'(lat), 64'(exp_lat));
        check({name, ":beats"}, 64'(baddr.size()), 64'(exp_beats));
        for (int i = 0; i < baddr.size() && i < exp_beats; i++)
            check({name, ":beat_addr"}, 64'(baddr[i]), 64'((addr & ~32'h3) + 32'(4 * i)));
        for (int s = 0; s < stall; s++) begin
            check({name, ":stall_valid"}, 64'(wb_valid), 64'd1);
            check({name, ":stall_data"}, 64'(wb_data), 64'(exp_data));
            check({name, ":stall_ready"}, 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        wb_ready = 1'b1;
        if (sb.size() == 0) begin
            check({name, ":sb_empty"}, 64'd1, 64'(sb.size()));
        end else begin
            got_e = sb.pop_front();
            check({name, ":wb_data"}, 64'(wb_data), 64'(got_e.data));
            check({name, ":wb_err"}, 64'(wb_err), 64'(got_e.err));
            check({name, ":wb_rd"}, 64'(wb_rd), 64'(got_e.rd));
        end
        @(posedge clk); #1;
        wb_ready = 1'b0;
        check({name, ":post_wb_valid"}, 64'(wb_valid), 64'd0);
        check({name, ":post_req_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        int bcount;
        bit bseen;
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_size = '0; req_unsigned = 1'b0; req_rd = '0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0; wb_ready = 1'b0;
        req_valid_b = 1'b0; wb_ready_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst:req_ready", 64'(req_ready), 64'd1);
        check("rst:mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst:wb_valid", 64'(wb_valid), 64'd0);
        check("rst:wb_err", 64'(wb_err), 64'd0);
        check("rst:wb_data", 64'(wb_data), 64'd0);
        check("rst:wb_rd", 64'(wb_rd), 64'd0);
        check("rst:mem_addr", 64'(mem_addr), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_load("lb_103",  32'h103, 2'd0, 1'b0, 5'd1, 32'hFFFF_FF88, 1'b0, 1, 3, 0);
        run_load("lhu_102", 32'h102, 2'd1, 1'b1, 5'd2, 32'h0000_8899, 1'b0, 1, 3, 0);
        run_load("lh_102",  32'h102, 2'd1, 1'b0, 5'd3, 32'hFFFF_8899, 1'b0, 1, 3, 0);
        run_load("lw_102",  32'h102, 2'd2, 1'b0, 5'd4, 32'h3344_8899, 1'b0, 2, 5, 0);
        run_load("ld_100",  32'h100, 2'd3, 1'b0, 5'd5, 32'h0000_0000, 1'b1, 0, 1, 0);
        run_load("lw_stall", 32'h100, 2'd2, 1'b0, 5'd6, 32'h8899_AABB, 1'b0, 1, 3, 5);
        run_load("lhu_103", 32'h103, 2'd1, 1'b1, 5'd10, 32'h0000_4488, 1'b0, 2, 5, 0);

        // Reset while the first beat is outstanding; the late response must be ignored.
        req_valid = 1'b1; req_addr = 32'h100; req_size = 2'd0; req_unsigned = 1'b0; req_rd = 5'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstmid:req_issued", 64'(mem_req_valid), 64'd1);
        @(posedge clk); #1;
        check("rstmid:in_wait0", 64'(mem_req_valid), 64'd0);
        rst = 1'b1; #2; rst = 1'b0;
        check("rstmid:req_ready", 64'(req_ready), 64'd1);
        mem_resp_valid = 1'b1; mem_resp_data = 32'h8899_AABB;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rstmid:no_wb", 64'(wb_valid), 64'd0);
            check("rstmid:idle", 64'(req_ready), 64'd1);
            @(posedge clk); #1;
        end
        run_load("lb_100", 32'h100, 2'd0, 1'b0, 5'd8, 32'hFFFF_FFBB, 1'b0, 1, 3, 0);

        // Instance B: word-crossing lw must error without touching memory.
        bcount = 0; bseen = 1'b0;
        check("na:req_ready", 64'(req_ready_b), 64'd1);
        req_valid_b = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            req_valid_b = 1'b0;
            if (mem_req_valid_b) bcount++;
            if (wb_valid_b) begin
                bseen = 1'b1;
                break;
            end
        end
        check("na:wb_seen", 64'(bseen), 64'd1);
        check("na:beats", 64'(bcount), 64'd0);
        check("na:wb_err", 64'(wb_err_b), 64'd1);
        check("na:wb_data", 64'(wb_data_b), 64'd0);
        check("na:wb_rd", 64'(wb_rd_b), 64'd9);
        wb_ready_b = 1'b1;
        @(posedge clk); #1;
        wb_ready_b = 1'b0;
        check("na:post_ready", 64'(req_ready_b), 64'd1);

        check("sb:drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 The parameter XLEN SHALL default to 32, be legal only at 32 or 64, and set the data path and address width.
REQ-002 The parameter ALLOW_MISALIGNED SHALL default to 1; 1 means word-crossing loads are split into two beats, 0 means they are reported as errors.
REQ-003 The clock SHALL be clk, 1 bit input; all state updates occur on its rising edge.
REQ-004 The reset SHALL be rst, 1 bit input, asynchronous and active-high.
REQ-005 The port req_valid SHALL be a 1-bit input: the pipeline presents a load.
REQ-006 The port req_ready SHALL be a 1-bit output: the unit accepts a load.
REQ-007 The port req_addr SHALL be an XLEN-bit input: the byte address.
REQ-008 The port req_size SHALL be a 2-bit input: 0=byte, 1=half, 2=word, 3=double.
REQ-009 The port req_unsigned SHALL be a 1-bit input: zero-extend instead of sign-extend.
REQ-010 The port req_rd SHALL be a 5-bit input: the destination tag.
REQ-011 The memory request ports SHALL be mem_req_valid (1-bit output), mem_req_ready (1-bit input) and mem_addr (XLEN-bit output, word-aligned).
REQ-012 The memory response ports SHALL be mem_resp_valid (1-bit input) and mem_resp_data (XLEN-bit input).
REQ-013 The writeback outputs SHALL be wb_valid (1 bit), wb_data (XLEN bits), wb_rd (5 bits) and wb_err (1 bit); the writeback input SHALL be wb_ready (1 bit).

Function
REQ-014 The unit SHALL have at most one load outstanding; FSM states are IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
REQ-015 req_ready SHALL equal 1 only in IDLE; on acceptance the unit latches addr, size, unsigned and rd, and enters REQ0 next cycle.
REQ-016 A load SHALL cross a word when offset + (1<<size) > XLEN/8, where offset = addr modulo XLEN/8.
REQ-017 An illegal load SHALL go IDLE -> RESP with wb_err=1 and wb_data=0 and make no memory access; illegal means size=3 with XLEN=32, or crossing with ALLOW_MISALIGNED=0.
REQ-018 In REQ0 the unit SHALL drive mem_req_valid=1 with mem_addr = addr with its low offset bits cleared, hold it until mem_req_ready, then go to WAIT0.
REQ-019 In WAIT0, mem_resp_valid SHALL load the lo register; the next state is REQ1 if the load crosses a word, else RESP.
REQ-020 REQ1 and WAIT1 SHALL repeat the REQ0/WAIT0 handshake at the aligned address + XLEN/8 (modulo 2^XLEN, wrapping), loading the hi register, then go to RESP.
REQ-021 mem_resp_valid SHALL be ignored in every state other than WAIT0 and WAIT1.
REQ-022 The result SHALL be formed from {hi,lo} shifted right by offset*8, truncated to 8<<size bits, then sign- or zero-extended to XLEN; req_unsigned is ignored when size equals XLEN.
REQ-023 In RESP, wb_valid SHALL be 1 and wb_data, wb_rd, wb_err SHALL be held stable until wb_ready=1, then the unit returns to IDLE.
REQ-024 Minimum latency for an aligned load SHALL be: accept at T, mem_req at T+1, response no earlier than T+2, wb_valid the cycle after the response.

Reset
REQ-025 Reset SHALL force IDLE, req_ready=1, mem_req_valid=0, wb_valid=0, wb_err=0, and clear wb_data, wb_rd, mem_addr, lo and hi to 0.
REQ-026 Reset asserted mid-operation SHALL abandon the load with no writeback; a later memory response for that load is ignored per REQ-021.

Structure
REQ-027 The shared package load_pkg SHALL hold the size encodings SZ_B/SZ_H/SZ_W/SZ_D and the FSM state enum.
REQ-028 The extraction and extension of REQ-022 SHALL live in one combinational sub-module, load_extract, parametrised by XLEN.

Verification (XLEN=32; mem[0x100]=0x8899AABB, mem[0x104]=0x11223344)
REQ-029 lb at 0x103 -> one memory beat, wb_data=0xFFFFFF88, wb_err=0.
REQ-030 lhu at 0x102 -> wb_data=0x00008899; lh at 0x102 -> wb_data=0xFFFF8899.
REQ-031 lw at 0x102 with ALLOW_MISALIGNED=1 -> two beats (0x100, 0x104), wb_data=0x33448899; with ALLOW_MISALIGNED=0 -> zero beats, wb_err=1, wb_data=0.
REQ-032 size=3 at 0x100 -> wb_err=1 with no memory request.
REQ-033 lw at 0x100 with wb_ready held low for 5 cycles -> wb_valid and wb_data=0x8899AABB stable throughout, req_ready=0 until handshake.
REQ-034 rst pulsed in WAIT0, then mem_resp_valid arrives -> no wb_valid, state IDLE, next lb at 0x100 returns 0xFFFFFFBB.
